// File: rtl/qam4_pkg.sv
// Constants shared by the QAM4 modulator and demodulator: bit/sign mapping, FSM encoding, default width.
package qam4_pkg;
  localparam int DEFAULT_DATA_W = 8;

  // Bit 0 rides on +A, bit 1 rides on -A.
  localparam logic BIT0_POS = 1'b0;
  localparam logic BIT1_NEG = 1'b1;

  localparam logic IDLE  = 1'b0;
  localparam logic ACCUM = 1'b1;
endpackage

// File: rtl/qam4_int_dump.sv
// One-rail integrate-and-dump; sum is the running total including the current sample.
// The register takes sum on load/add, and clear wins over both.
module qam4_int_dump #(
  parameter int DATA_W = 8,
  parameter int SPS    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             load,
  input  logic                             add,
  input  logic signed [DATA_W-1:0]         sample,
  output logic signed [DATA_W+$clog2(SPS):0] sum
);
  localparam int ACC_W = DATA_W + $clog2(SPS) + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
  // A load starts a fresh symbol, so the stale accumulator is ignored.
  assign sum = (load ? '0 : acc) + sample_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load || add) begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/qam4_demod.sv
// QAM4 demodulator: per-rail integrate-and-dump over SPS samples, sign decision, one-entry valid/ready output.
// Optional QAM4_DEMOD_STATS_EN adds sym_count and tie_count outputs.
module qam4_demod
  import qam4_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SPS    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     sym_start,
  output logic                     out_valid,
  output logic [1:0]               out_bits,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     align_err
`ifdef QAM4_DEMOD_STATS_EN
  ,
  output logic [31:0]              sym_count,
  output logic [15:0]              tie_count
`endif
);
  localparam int ACC_W = DATA_W + $clog2(SPS) + 1;
  localparam int CNT_W = $clog2(SPS + 1);

  logic                    state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    first;
  logic                    cont;
  logic                    take;
  logic                    decide;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic [1:0]              dec_bits;

  always_comb begin
    first       = in_valid && sym_start;
    cont        = in_valid && !sym_start && (state == ACCUM);
    take        = first || cont;
    cnt_nxt     = first ? CNT_W'(1) : cnt + CNT_W'(1);
    decide      = take && (cnt_nxt == CNT_W'(SPS));
    dec_bits[1] = sum_i[ACC_W-1] ? BIT1_NEG : BIT0_POS;
    dec_bits[0] = sum_q[ACC_W-1] ? BIT1_NEG : BIT0_POS;
  end

  qam4_int_dump #(.DATA_W(DATA_W), .SPS(SPS)) u_rail_i (
    .clk(clk), .reset(reset), .clear(decide), .load(first), .add(cont),
    .sample(in_i), .sum(sum_i)
  );

  qam4_int_dump #(.DATA_W(DATA_W), .SPS(SPS)) u_rail_q (
    .clk(clk), .reset(reset), .clear(decide), .load(first), .add(cont),
    .sample(in_q), .sum(sum_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bits  <= 2'b00;
      overflow  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (first) state <= ACCUM;
      // A sym_start with a partial symbol in flight means the source lost alignment.
      if (first && (state == ACCUM) && (cnt != '0)) align_err <= 1'b1;

      if (decide)    cnt <= '0;
      else if (take) cnt <= cnt_nxt;

      if (decide) begin
        if (!out_valid || out_ready) begin
          out_bits  <= dec_bits;
          out_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef QAM4_DEMOD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_count <= '0;
      tie_count <= '0;
    end else if (decide) begin
      sym_count <= sym_count + 32'd1;
      if (((sum_i == '0) || (sum_q == '0)) && (tie_count != 16'hFFFF))
        tie_count <= tie_count + 16'd1;
    end
  end
`endif
endmodule
